// File: rtl/fpm_final_add.sv
// Final 3:2 compress + split 48-bit carry-propagate add of the FP multiplier; 3-cycle latency, one product per cycle.
// Valid/ready pipeline: a stalled stage holds; the only combinational path is the out_ready -> in_ready chain.
module fpm_final_add #(
  parameter int OFF1 = 1,
  parameter int OFF2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] red5_0,
  input  logic [45:0] red5_1,
  input  logic [43:0] red5_2,
  input  logic [7:0]  in_tag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] prod,
  output logic        sticky,
  output logic [7:0]  out_tag
);

  typedef struct packed {
    logic [47:0] r0;
    logic [47:0] r1;
    logic [47:0] r2;
    logic [7:0]  tag;
  } rows_t;

  typedef struct packed {
    logic [23:0] hs;
    logic [23:0] hc;
    logic [23:0] lo;
    logic        c24;
    logic [7:0]  tag;
  } half_t;

  logic        s1_vld, s2_vld, s3_vld;
  logic        s1_adv, s2_adv, s3_adv;
  rows_t       s1_q, s1_d;
  half_t       s2_q, s2_d;
  logic [47:0] csa_sum, csa_carry;
  logic [24:0] lo_sum;
  logic [23:0] hi_sum;

  // Ready chain: each stage may move if it is empty or the stage after it moves.
  assign s3_adv    = !s3_vld || out_ready;
  assign s2_adv    = !s2_vld || s3_adv;
  assign s1_adv    = !s1_vld || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s3_vld;

  always_comb begin
    s1_d     = '0;
    s1_d.r0  = red5_0;
    s1_d.r1  = {2'b00, red5_1} << OFF1;
    s1_d.r2  = {4'b0000, red5_2} << OFF2;
    s1_d.tag = in_tag;
  end

  always_comb begin
    csa_sum   = s1_q.r0 ^ s1_q.r1 ^ s1_q.r2;
    csa_carry = ((s1_q.r0 & s1_q.r1) | (s1_q.r0 & s1_q.r2) | (s1_q.r1 & s1_q.r2)) << 1;
    lo_sum    = {1'b0, csa_sum[23:0]} + {1'b0, csa_carry[23:0]};
    s2_d      = '0;
    s2_d.hs   = csa_sum[47:24];
    s2_d.hc   = csa_carry[47:24];
    s2_d.lo   = lo_sum[23:0];
    s2_d.c24  = lo_sum[24];
    s2_d.tag  = s1_q.tag;
  end

  // Carry out of bit 47 falls off the 24-bit result.
  assign hi_sum = s2_q.hs + s2_q.hc + {23'd0, s2_q.c24};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      s3_vld  <= 1'b0;
      prod    <= '0;
      sticky  <= 1'b0;
      out_tag <= '0;
    end else begin
      if (s1_adv) s1_vld <= in_valid;
      if (s2_adv) s2_vld <= s1_vld;
      if (s3_adv) s3_vld <= s2_vld;
      if (s3_adv && s2_vld) begin
        prod    <= {hi_sum, s2_q.lo};
        sticky  <= |s2_q.lo[21:0];
        out_tag <= s2_q.tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) s1_q <= s1_d;
    if (s2_adv && s1_vld)   s2_q <= s2_d;
  end

endmodule

// File: tb/tb_fpm_final_add.sv
// Directed and randomized checks of fpm_final_add against an arithmetic reference model and scoreboard.
module tb_fpm_final_add;
  localparam int OFF1 = 1;
  localparam int OFF2 = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] red5_0 = '0;
  logic [45:0] red5_1 = '0;
  logic [43:0] red5_2 = '0;
  logic [7:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [47:0] prod;
  logic        sticky;
  logic [7:0]  out_tag;

  typedef struct {
    logic [47:0] prod;
    logic        sticky;
    logic [7:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  fpm_final_add #(.OFF1(OFF1), .OFF2(OFF2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .red5_0(red5_0), .red5_1(red5_1), .red5_2(red5_2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .prod(prod), .sticky(sticky), .out_tag(out_tag)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] want);
    compared++;
    assert (obs === want) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", name, obs, want);
    end
  endtask

  // Reference: plain weighted sum of the three rows, reduced mod 2^48.
  function automatic exp_t model(input logic [47:0] a, input logic [45:0] b,
                                 input logic [43:0] c, input logic [7:0] t);
    exp_t        e;
    logic [63:0] s;
    s = {16'd0, a} + ({18'd0, b} << OFF1) + ({20'd0, c} << OFF2);
    e.prod   = s[47:0];
    e.sticky = (s[21:0] != 22'd0);
    e.tag    = t;
    return e;
  endfunction

  // One clock: sample handshakes mid-cycle, update scoreboard, then step past the edge.
  task automatic cycle(output bit acc);
    exp_t e;
    #4;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_output", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("sb_prod", 64'(prod), 64'(e.prod));
        check("sb_sticky", 64'(sticky), 64'(e.sticky));
        check("sb_tag", 64'(out_tag), 64'(e.tag));
      end
    end
    if (acc) exp_q.push_back(model(red5_0, red5_1, red5_2, in_tag));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [47:0] a, input logic [45:0] b,
                      input logic [43:0] c, input logic [7:0] t);
    bit acc;
    acc = 1'b0;
    red5_0 = a; red5_1 = b; red5_2 = c; in_tag = t; in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) cycle(acc);
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    bit acc;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) cycle(acc);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_out_valid", 64'(out_valid), 64'd0);
  endtask

  // Lone transaction into an empty pipe: result visible after the third edge counting the accept edge.
  task automatic single(input string id, input logic [47:0] a, input logic [45:0] b,
                        input logic [43:0] c, input logic [7:0] t,
                        input logic [47:0] wp, input logic ws);
    bit acc;
    out_ready = 1'b1;
    send(a, b, c, t);
    check({id, "_lat1"}, 64'(out_valid), 64'd0);
    cycle(acc);
    check({id, "_lat2"}, 64'(out_valid), 64'd0);
    cycle(acc);
    check({id, "_valid"}, 64'(out_valid), 64'd1);
    check({id, "_prod"}, 64'(prod), 64'(wp));
    check({id, "_sticky"}, 64'(sticky), 64'(ws));
    check({id, "_tag"}, 64'(out_tag), 64'(t));
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    exp_t        e;
    logic [47:0] hold;
    logic [47:0] ra;
    logic [45:0] rb;
    logic [43:0] rc;
    int          sent;
    int          pat;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_prod", 64'(prod), 64'd0);
    check("rst_sticky", 64'(sticky), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    single("bit_r0", 48'd1, 46'd0, 44'd0, 8'h11, 48'h000000000001, 1'b1);
    single("bit_r1", 48'd0, 46'd1, 44'd0, 8'h12, 48'h000000000002, 1'b1);
    single("bit_r2", 48'd0, 46'd0, 44'd1, 8'h13, 48'h000000000010, 1'b1);
    // (2^48-1) + (2^46-1)*2 + (2^44-1)*16 = 2^49 + 2^47 - 19 -> 2^47 - 19 mod 2^48
    single("wrap", '1, '1, '1, 8'h14, 48'h7FFFFFFFFFED, 1'b1);

    // Cross-half carry followed immediately by a value with an empty low half.
    out_ready = 1'b1;
    send(48'h000000FFFFFF, 46'd1, 44'd0, 8'h21);
    send(48'h800000000000, 46'd0, 44'd0, 8'h22);
    check("xc_lat", 64'(out_valid), 64'd0);
    cycle(acc);
    check("xc_a_valid", 64'(out_valid), 64'd1);
    check("xc_a_prod", 64'(prod), 64'h000001000001);
    check("xc_a_sticky", 64'(sticky), 64'd1);
    cycle(acc);
    check("xc_b_valid", 64'(out_valid), 64'd1);
    check("xc_b_prod", 64'(prod), 64'h800000000000);
    check("xc_b_sticky", 64'(sticky), 64'd0);
    check("xc_b_tag", 64'(out_tag), 64'h22);
    drain();

    // Backpressure: three fill the pipe, then the head must hold still.
    out_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      check("bp_ready_before", 64'(in_ready), 64'd1);
      send(48'({$urandom(), $urandom()}), 46'({$urandom(), $urandom()}),
           44'({$urandom(), $urandom()}), 8'(t));
    end
    check("bp_ready_full", 64'(in_ready), 64'd0);
    check("bp_head_valid", 64'(out_valid), 64'd1);
    check("bp_head_tag", 64'(out_tag), 64'd1);
    hold = prod;
    red5_0 = 48'({$urandom(), $urandom()});
    red5_1 = 46'({$urandom(), $urandom()});
    red5_2 = 44'({$urandom(), $urandom()});
    in_tag = 8'd4;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle(acc);
      check("bp_no_accept", 64'(acc), 64'd0);
      check("bp_prod_stable", 64'(prod), 64'(hold));
      check("bp_tag_stable", 64'(out_tag), 64'd1);
    end
    out_ready = 1'b1;
    cycle(acc);
    check("bp_accept_on_release", 64'(acc), 64'd1);
    send(48'({$urandom(), $urandom()}), 46'({$urandom(), $urandom()}),
         44'({$urandom(), $urandom()}), 8'd5);
    for (int t = 3; t <= 5; t++) begin
      check("bp_stream_valid", 64'(out_valid), 64'd1);
      check("bp_stream_tag", 64'(out_tag), 64'(t));
      cycle(acc);
    end
    drain();

    // Reset with three transactions in flight drops them.
    out_ready = 1'b0;
    for (int t = 0; t < 3; t++)
      send(48'({$urandom(), $urandom()}), 46'({$urandom(), $urandom()}),
           44'({$urandom(), $urandom()}), 8'(8'h30 + t));
    rst = 1'b1;
    cycle(acc);
    rst = 1'b0;
    exp_q.delete();
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_prod", 64'(prod), 64'd0);
    check("mrst_sticky", 64'(sticky), 64'd0);
    check("mrst_out_tag", 64'(out_tag), 64'd0);
    check("mrst_in_ready", 64'(in_ready), 64'd1);
    ra = 48'({$urandom(), $urandom()});
    rb = 46'({$urandom(), $urandom()});
    rc = 44'({$urandom(), $urandom()});
    e = model(ra, rb, rc, 8'h3F);
    single("mrst_next", ra, rb, rc, 8'h3F, e.prod, e.sticky);

    // Random regression with random downstream stalls.
    sent = 0;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 40000 && sent < 10000; cyc++) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        pat = int'($urandom_range(0, 7));
        if (pat == 0) begin
          red5_0 = '1; red5_1 = '1; red5_2 = '1;
        end else if (pat == 1) begin
          red5_0 = '0; red5_1 = '0; red5_2 = '0;
        end else begin
          red5_0 = 48'({$urandom(), $urandom()});
          red5_1 = 46'({$urandom(), $urandom()});
          red5_2 = 44'({$urandom(), $urandom()});
        end
        in_tag = 8'($urandom());
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 9) < 7);
      cycle(acc);
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("rand_sent", 64'(sent), 64'd10000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
